// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: default widths, reset PC and the prefetch queue entry.
package cpu_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int INSN_BYTES   = 4;
  localparam logic [XLEN_DEFAULT-1:0] RESET_PC_DEFAULT = '0;

  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] pc;
    logic [31:0]             insn;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch queue of fetch entries; flush wins over push and pop.
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int  DEPTH   = 4,
  parameter type entry_t = fetch_entry_t,
  localparam int PW      = $clog2(DEPTH),
  localparam int CW      = PW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  input  entry_t        wdata,
  output entry_t        rdata,
  output logic [CW-1:0] occ
);
  entry_t [DEPTH-1:0] mem_q, mem_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] occ_q, occ_d;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
      occ_d = occ_q + CW'(push) - CW'(pop);
    end
  end

  // Storage carries no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign occ   = occ_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (reset)
                    !(push && !flush && !pop && occ_q == CW'(DEPTH)));
  a_no_underflow: assert property (@(posedge clk) disable iff (reset)
                    !(pop && !flush && occ_q == '0));
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, request credit, stale-response dropping, prefetch queue.
// Optional FETCH_BYPASS_EN: a kept response reaches decode combinationally when the queue is empty.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEFAULT,
  parameter int               DEPTH    = 4,
  parameter logic [XLEN-1:0]  RESET_PC = XLEN'(RESET_PC_DEFAULT)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            jump_flag,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            insn_valid,
  input  logic            insn_ready,
  output logic [XLEN-1:0] insn_pc,
  output logic [31:0]     insn_data
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 1;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     insn;
  } entry_t;

  logic [XLEN-1:0] fpc_q, fpc_d, rpc_q, rpc_d, tgt;
  logic [CW-1:0]   outst_q, outst_d, drop_q, drop_d, occ;
  logic            grant, keep, push, pop, bypass;
  entry_t          head, wentry;

  fetch_fifo #(.DEPTH(DEPTH), .entry_t(entry_t)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .flush (jump_flag),
    .push  (push),
    .pop   (pop),
    .wdata (wentry),
    .rdata (head),
    .occ   (occ)
  );

  always_comb begin
    tgt       = jump_target & ~XLEN'(INSN_BYTES - 1);
    imem_req  = !reset && !jump_flag && ((SW'(occ) + SW'(outst_q)) < SW'(DEPTH));
    imem_addr = fpc_q;
    grant     = imem_req && imem_gnt;
    keep      = imem_rvalid && !jump_flag && (drop_q == '0);
    wentry    = '{pc: rpc_q, insn: imem_rdata};

    // An empty queue shows the next expected PC with a zero word.
    insn_valid = (occ != '0) && !jump_flag;
    insn_pc    = (occ != '0) ? head.pc : rpc_q;
    insn_data  = (occ != '0) ? head.insn : '0;
    bypass     = 1'b0;
`ifdef FETCH_BYPASS_EN
    if (keep && occ == '0) begin
      insn_valid = 1'b1;
      insn_pc    = rpc_q;
      insn_data  = imem_rdata;
      bypass     = insn_ready;
    end
`endif
    push = keep && !bypass;
    pop  = (occ != '0) && !jump_flag && insn_ready;

    fpc_d   = grant ? fpc_q + XLEN'(INSN_BYTES) : fpc_q;
    rpc_d   = keep ? rpc_q + XLEN'(INSN_BYTES) : rpc_q;
    outst_d = outst_q + CW'(grant) - CW'(imem_rvalid);
    drop_d  = (imem_rvalid && drop_q != '0) ? drop_q - CW'(1) : drop_q;
    // Everything still in flight after this cycle's response predates the redirect.
    if (jump_flag) begin
      fpc_d  = tgt;
      rpc_d  = tgt;
      drop_d = outst_q - CW'(imem_rvalid);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fpc_q   <= RESET_PC;
      rpc_q   <= RESET_PC;
      outst_q <= '0;
      drop_q  <= '0;
    end else begin
      fpc_q   <= fpc_d;
      rpc_q   <= rpc_d;
      outst_q <= outst_d;
      drop_q  <= drop_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed cycle table, corner sequences, randomized run vs. program-order model.
module tb_fetch_unit;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, reset = 1'b1, jump_flag = 1'b0, imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0, insn_ready = 1'b0;
  logic [31:0] jump_target = '0, imem_rdata = '0;
  logic        imem_req, insn_valid;
  logic [31:0] imem_addr, insn_pc, insn_data;

  fetch_unit #(.XLEN(32), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .reset(reset), .jump_flag(jump_flag), .jump_target(jump_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .insn_valid(insn_valid),
    .insn_ready(insn_ready), .insn_pc(insn_pc), .insn_data(insn_data)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0, consumed = 0;
  int lat = 1, gnt_pct = 100;
  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] pc_log[$];
  logic [31:0] exp_pc, exp_faddr;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  // Memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %h want %h", nm, cyc, act, exp);
    end
  endtask

  // One clock: memory drives its response, outputs settle and are checked
  // against program order (consumed PCs run sequentially from the last redirect).
  task automatic cycle();
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = memf(pend_addr[0]);
    end
    imem_gnt = ($urandom_range(99) < gnt_pct);
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = insn_valid; s_pc = insn_pc;
    if (imem_rvalid) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    if (imem_req) chk("fetch_addr", imem_addr, exp_faddr);
    if (imem_req && imem_gnt) begin
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      exp_faddr = exp_faddr + 32'd4;
    end
    if (jump_flag) begin
      chk("req_in_jump", 32'(imem_req), 32'd0);
      chk("valid_in_jump", 32'(insn_valid), 32'd0);
      exp_pc    = jump_target & ~32'd3;
      exp_faddr = jump_target & ~32'd3;
    end else if (insn_valid && insn_ready) begin
      chk("insn_pc", insn_pc, exp_pc);
      chk("insn_data", insn_data, memf(exp_pc));
      pc_log.push_back(insn_pc);
      exp_pc = exp_pc + 32'd4;
      consumed++;
    end
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    reset = 1'b1; jump_flag = 1'b0; insn_ready = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    pend_addr.delete(); pend_due.delete(); pc_log.delete();
    @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(insn_valid), 32'd0);
    chk("rst_pc", insn_pc, 32'h0);
    chk("rst_data", insn_data, 32'h0);
    reset = 1'b0; cyc = 0; exp_pc = '0; exp_faddr = '0;
  endtask

  typedef struct {
    logic        jmp;
    logic [31:0] tgt;
    logic        rdy;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_pc;
  } vec_t;

  vec_t tbl[16];

  initial begin
    // 1-cycle memory, always granting: startup, jump colliding with rvalid+pop, backpressure.
    tbl[0]  = '{0, 32'h0,   1, 1, 32'h000, 0, 32'h0};
    tbl[1]  = '{0, 32'h0,   1, 1, 32'h004, 0, 32'h0};
    tbl[2]  = '{0, 32'h0,   1, 1, 32'h008, 1, 32'h000};
    tbl[3]  = '{0, 32'h0,   1, 1, 32'h00C, 1, 32'h004};
    tbl[4]  = '{1, 32'h103, 1, 0, 32'h0,   0, 32'h0};
    tbl[5]  = '{0, 32'h0,   1, 1, 32'h100, 0, 32'h0};
    tbl[6]  = '{0, 32'h0,   1, 1, 32'h104, 0, 32'h0};
    tbl[7]  = '{0, 32'h0,   1, 1, 32'h108, 1, 32'h100};
    tbl[8]  = '{0, 32'h0,   0, 1, 32'h10C, 1, 32'h104};
    tbl[9]  = '{0, 32'h0,   0, 1, 32'h110, 1, 32'h104};
    tbl[10] = '{0, 32'h0,   0, 0, 32'h0,   1, 32'h104};
    tbl[11] = '{0, 32'h0,   0, 0, 32'h0,   1, 32'h104};
    tbl[12] = '{0, 32'h0,   1, 0, 32'h0,   1, 32'h104};
    tbl[13] = '{0, 32'h0,   1, 1, 32'h114, 1, 32'h108};
    tbl[14] = '{0, 32'h0,   1, 1, 32'h118, 1, 32'h10C};
    tbl[15] = '{0, 32'h0,   1, 1, 32'h11C, 1, 32'h110};

    do_reset();
`ifndef FETCH_BYPASS_EN
    lat = 1; gnt_pct = 100;
    for (int i = 0; i < 16; i++) begin
      jump_flag = tbl[i].jmp; jump_target = tbl[i].tgt; insn_ready = tbl[i].rdy;
      cycle();
      chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].e_req));
      chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].e_valid));
      if (tbl[i].e_req) chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].e_addr);
      if (tbl[i].e_valid) chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].e_pc);
    end
    jump_flag = 1'b0;
`endif

    // First valid timing with 1-cycle memory.
    do_reset();
    lat = 1; gnt_pct = 100; insn_ready = 1'b1;
    begin
      int first_v = -1;
      for (int i = 0; i < 6; i++) begin
        cycle();
        if (s_valid && first_v < 0) first_v = cyc - 1;
      end
`ifdef FETCH_BYPASS_EN
      chk("first_valid_cyc", 32'(first_v), 32'd1);
`else
      chk("first_valid_cyc", 32'(first_v), 32'd2);
`endif
    end

    // Jump with two requests outstanding, 3-cycle memory.
    do_reset();
    lat = 3; insn_ready = 1'b1;
    cycle(); cycle();
    chk("j2_outst", 32'(pend_addr.size()), 32'd2);
    jump_flag = 1'b1; jump_target = 32'h103;
    cycle();
    jump_flag = 1'b0;
    cycle();
    chk("j2_req_t1", 32'(s_req), 32'd1);
    chk("j2_addr_t1", s_addr, 32'h100);
    pc_log.delete();
    for (int i = 0; i < 12; i++) cycle();
    chk("j2_first_pc", pc_log.size() > 0 ? pc_log[0] : 32'hDEAD_BEEF, 32'h100);

    // Back-to-back jumps: only the second target is fetched.
    jump_flag = 1'b1; jump_target = 32'h200;
    cycle();
    jump_target = 32'h300;
    cycle();
    jump_flag = 1'b0;
    cycle();
    chk("b2b_addr", s_addr, 32'h300);
    pc_log.delete();
    for (int i = 0; i < 12; i++) cycle();
    chk("b2b_first_pc", pc_log.size() > 0 ? pc_log[0] : 32'hDEAD_BEEF, 32'h300);

    // PC wrap at the top of the address space.
    lat = 1;
    jump_flag = 1'b1; jump_target = 32'hFFFF_FFFC;
    cycle();
    jump_flag = 1'b0;
    pc_log.delete();
    for (int i = 0; i < 8; i++) cycle();
    chk("wrap_pc0", pc_log.size() > 1 ? pc_log[0] : 32'hDEAD_BEEF, 32'hFFFF_FFFC);
    chk("wrap_pc1", pc_log.size() > 1 ? pc_log[1] : 32'hDEAD_BEEF, 32'h0000_0000);

    // Randomized traffic: random grants, latency, backpressure and redirects.
    for (int ph = 0; ph < 4; ph++) begin
      do_reset();
      consumed = 0;
      lat = ph + 1; gnt_pct = 60 + 10 * ph;
      for (int i = 0; i < 1500; i++) begin
        insn_ready = ($urandom_range(99) < 65);
        jump_flag  = ($urandom_range(99) < 3);
        jump_target = ($urandom_range(3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                                : $urandom;
        cycle();
      end
      jump_flag = 1'b0;
      chk($sformatf("rand%0d_progress", ph), 32'(consumed > 200), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
